// File: rtl/logic_unit_pkg.sv
// Shared types and op truth tables for the pipelined bitwise logic unit.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        LOP_AND   = 3'd0,
        LOP_OR    = 3'd1,
        LOP_XOR   = 3'd2,
        LOP_NOR   = 3'd3,
        LOP_NAND  = 3'd4,
        LOP_XNOR  = 3'd5,
        LOP_ANDN  = 3'd6,
        LOP_PASSA = 3'd7
    } logic_op_e;

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_XNOR  = 4'b1001;
    localparam logic [3:0] TT_ANDN  = 4'b0100;
    localparam logic [3:0] TT_PASSA = 4'b1100;

    function automatic logic [3:0] op_truth(input logic_op_e op);
        logic [3:0] tt;
        case (op)
            LOP_AND:   tt = TT_AND;
            LOP_OR:    tt = TT_OR;
            LOP_XOR:   tt = TT_XOR;
            LOP_NOR:   tt = TT_NOR;
            LOP_NAND:  tt = TT_NAND;
            LOP_XNOR:  tt = TT_XNOR;
            LOP_ANDN:  tt = TT_ANDN;
            default:   tt = TT_PASSA;
        endcase
        return tt;
    endfunction

endpackage

// File: rtl/zero_detect.sv
// Combinational all-zero detector (wide NOR reduction) for a WIDTH-bit word.
module zero_detect #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data,
    output logic             zero
);

    assign zero = ~|data;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with zero/negative/lane-zero flags.
// Optional sticky flag accumulation is enabled by defining LOGIC_UNIT_STICKY_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_negative,
    output logic [LANES-1:0] out_lane_zero,
    input  logic             sticky_clear,
    output logic             sticky_zero,
    output logic             sticky_negative
);

    localparam int LW = WIDTH / LANES;

    logic [3:0]       truth;
    logic [WIDTH-1:0] func_result;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_result;
    logic             s1_zero;
    logic [LANES-1:0] s1_lane_zero;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_negative;
    logic [LANES-1:0] s2_lane_zero;

    logic             s1_load;
    logic             s2_load;

    assign truth = op_truth(logic_op_e'(in_op));

    always_comb begin
        func_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            func_result[i] = truth[{in_a[i], in_b[i]}];
        end
    end

    // in_ready depends only on register state and out_ready, never on in_valid.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_result <= func_result;
            end
        end
    end

    zero_detect #(.WIDTH(WIDTH)) u_word_zero (
        .data (s1_result),
        .zero (s1_zero)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        zero_detect #(.WIDTH(LW)) u_lane_zero (
            .data (s1_result[k*LW +: LW]),
            .zero (s1_lane_zero[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid     <= 1'b0;
            s2_result    <= '0;
            s2_zero      <= 1'b0;
            s2_negative  <= 1'b0;
            s2_lane_zero <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result    <= s1_result;
                s2_zero      <= s1_zero;
                s2_negative  <= s1_result[WIDTH-1];
                s2_lane_zero <= s1_lane_zero;
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_result    = s2_result;
    assign out_zero      = s2_zero;
    assign out_negative  = s2_negative;
    assign out_lane_zero = s2_lane_zero;

`ifdef LOGIC_UNIT_STICKY_EN
    logic sticky_zero_q;
    logic sticky_negative_q;

    // Clear wins over an accumulate landing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_zero_q     <= 1'b0;
            sticky_negative_q <= 1'b0;
        end else if (sticky_clear) begin
            sticky_zero_q     <= 1'b0;
            sticky_negative_q <= 1'b0;
        end else if (s2_valid && out_ready) begin
            sticky_zero_q     <= sticky_zero_q | s2_zero;
            sticky_negative_q <= sticky_negative_q | s2_negative;
        end
    end

    assign sticky_zero     = sticky_zero_q;
    assign sticky_negative = sticky_negative_q;
`else
    logic unused_sticky_clear;
    assign unused_sticky_clear = sticky_clear;
    assign sticky_zero         = 1'b0;
    assign sticky_negative     = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (LANES=1 and LANES=4 instances).
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

`ifdef LOGIC_UNIT_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic        sticky_clear;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [2:0]  in_op;

    logic        in_ready1, out_valid1, out_zero1, out_negative1, sticky_zero1, sticky_negative1;
    logic [63:0] out_result1;
    logic [0:0]  out_lane_zero1;

    logic        in_ready4, out_valid4, out_zero4, out_negative4, sticky_zero4, sticky_negative4;
    logic [63:0] out_result4;
    logic [3:0]  out_lane_zero4;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(64), .LANES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid1),
        .out_ready(out_ready), .out_result(out_result1), .out_zero(out_zero1),
        .out_negative(out_negative1), .out_lane_zero(out_lane_zero1),
        .sticky_clear(sticky_clear), .sticky_zero(sticky_zero1),
        .sticky_negative(sticky_negative1)
    );

    logic_unit_pipe #(.WIDTH(64), .LANES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
        .out_ready(out_ready), .out_result(out_result4), .out_zero(out_zero4),
        .out_negative(out_negative4), .out_lane_zero(out_lane_zero4),
        .sticky_clear(sticky_clear), .sticky_zero(sticky_zero4),
        .sticky_negative(sticky_negative4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = valid;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat through an empty pipe with out_ready high; ends after delivery.
    task automatic single(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] expRes, input logic expZero, input logic expNeg,
                          input logic [3:0] expLz4);
        applyStimulus(1'b1, op, a, b);
        step();
        applyStimulus(1'b0, 3'd0, 64'd0, 64'd0);
        checkOutput({tag, "_lat1_valid"}, {63'd0, out_valid1}, 64'd0);
        step();
        checkOutput({tag, "_valid"}, {63'd0, out_valid1}, 64'd1);
        checkOutput({tag, "_result"}, out_result1, expRes);
        checkOutput({tag, "_zero"}, {63'd0, out_zero1}, {63'd0, expZero});
        checkOutput({tag, "_neg"}, {63'd0, out_negative1}, {63'd0, expNeg});
        checkOutput({tag, "_lz1"}, {63'd0, out_lane_zero1}, {63'd0, expZero});
        checkOutput({tag, "_result4"}, out_result4, expRes);
        checkOutput({tag, "_lz4"}, {60'd0, out_lane_zero4}, {60'd0, expLz4});
        step();
    endtask

    logic [63:0] sweepExp [8];
    logic [63:0] bpData [6];

    initial begin
        sweepExp[0] = 64'hF000_F000_F000_F000;
        sweepExp[1] = 64'hFFF0_FFF0_FFF0_FFF0;
        sweepExp[2] = 64'h0FF0_0FF0_0FF0_0FF0;
        sweepExp[3] = 64'h000F_000F_000F_000F;
        sweepExp[4] = 64'h0FFF_0FFF_0FFF_0FFF;
        sweepExp[5] = 64'hF00F_F00F_F00F_F00F;
        sweepExp[6] = 64'h00F0_00F0_00F0_00F0;
        sweepExp[7] = 64'hF0F0_F0F0_F0F0_F0F0;
        bpData[0] = 64'h1111_0000_0000_0001;
        bpData[1] = 64'h2222_0000_0000_0002;
        bpData[2] = 64'h3333_0000_0000_0003;
        bpData[3] = 64'h4444_0000_0000_0004;
        bpData[4] = 64'h5555_0000_0000_0005;
        bpData[5] = 64'h6666_0000_0000_0006;

        reset_n      = 1'b0;
        out_ready    = 1'b1;
        sticky_clear = 1'b0;
        applyStimulus(1'b0, 3'd0, 64'd0, 64'd0);
        step();
        step();
        $display("[TB] reset state");
        checkOutput("rst_out_valid", {63'd0, out_valid1}, 64'd0);
        checkOutput("rst_out_result", out_result1, 64'd0);
        checkOutput("rst_out_zero", {63'd0, out_zero1}, 64'd0);
        checkOutput("rst_out_neg", {63'd0, out_negative1}, 64'd0);
        checkOutput("rst_lz4", {60'd0, out_lane_zero4}, 64'd0);
        checkOutput("rst_sticky", {62'd0, sticky_zero1, sticky_negative1}, 64'd0);
        reset_n = 1'b1;
        step();
        checkOutput("post_rst_in_ready", {63'd0, in_ready1}, 64'd1);

        $display("[TB] basic OR / NOR beats");
        single("or_ones", LOP_OR, 64'h1, ALL1, ALL1, 1'b0, 1'b1, 4'b0000);
        single("or_zero", LOP_OR, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'b1111);
        single("nor_zero", LOP_NOR, 64'd0, 64'd0, ALL1, 1'b0, 1'b1, 4'b0000);

        $display("[TB] op sweep, back to back");
        for (int i = 0; i < 9; i++) begin
            if (i < 8) applyStimulus(1'b1, 3'(i), 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
            else       applyStimulus(1'b0, 3'd0, 64'd0, 64'd0);
            step();
            if (i >= 1) begin
                checkOutput($sformatf("sweep%0d_valid", i - 1), {63'd0, out_valid1}, 64'd1);
                checkOutput($sformatf("sweep%0d_result", i - 1), out_result1, sweepExp[i-1]);
                checkOutput($sformatf("sweep%0d_neg", i - 1), {63'd0, out_negative1}, {63'd0, sweepExp[i-1][63]});
            end
        end

        $display("[TB] lane zeros");
        single("lanes", LOP_OR, 64'h0000_1234_0000_0000, 64'h1, 64'h0000_1234_0000_0001, 1'b0, 1'b0, 4'b1010);

        $display("[TB] backpressure stream");
        begin
            int nextBeat  = 0;
            int delivered = 0;
            logic accepted;
            for (int c = 0; c < 14; c++) begin
                if (nextBeat < 6) applyStimulus(1'b1, LOP_PASSA, bpData[nextBeat], 64'd0);
                else              applyStimulus(1'b0, 3'd0, 64'd0, 64'd0);
                out_ready = !(c >= 3 && c <= 6);
                #1;
                checkOutput($sformatf("bp_in_ready_c%0d", c), {63'd0, in_ready1},
                            (c >= 3 && c <= 6) ? 64'd0 : 64'd1);
                if (c >= 3 && c <= 6) begin
                    checkOutput($sformatf("bp_stall_valid_c%0d", c), {63'd0, out_valid1}, 64'd1);
                    checkOutput($sformatf("bp_stall_result_c%0d", c), out_result1, bpData[1]);
                end
                if (out_valid1 && out_ready) begin
                    checkOutput($sformatf("bp_deliver%0d", delivered), out_result1,
                                (delivered < 6) ? bpData[delivered] : 64'hDEAD_DEAD_DEAD_DEAD);
                    delivered++;
                end
                accepted = in_valid && in_ready1;
                step();
                if (accepted) nextBeat++;
            end
            checkOutput("bp_accepted_count", 64'(nextBeat), 64'd6);
            checkOutput("bp_delivered_count", 64'(delivered), 64'd6);
        end
        out_ready = 1'b1;

        $display("[TB] sticky flags");
        sticky_clear = 1'b1;
        step();
        sticky_clear = 1'b0;
        checkOutput("sticky_after_clear", {62'd0, sticky_zero1, sticky_negative1}, 64'd0);
        single("st_zero", LOP_OR, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'b1111);
        checkOutput("sticky_zero_set", {63'd0, sticky_zero1}, {63'd0, STICKY});
        checkOutput("sticky_neg_clear", {63'd0, sticky_negative1}, 64'd0);
        single("st_nonzero", LOP_OR, 64'd0, 64'h1, 64'h1, 1'b0, 1'b0, 4'b1110);
        checkOutput("sticky_zero_held", {63'd0, sticky_zero1}, {63'd0, STICKY});
        applyStimulus(1'b1, LOP_OR, 64'd0, 64'd0);
        step();
        applyStimulus(1'b0, 3'd0, 64'd0, 64'd0);
        step();
        checkOutput("clr_deliver_zero", {62'd0, out_valid1, out_zero1}, 64'd3);
        sticky_clear = 1'b1;
        step();
        sticky_clear = 1'b0;
        checkOutput("sticky_clear_priority", {63'd0, sticky_zero1}, 64'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, LOP_OR, 64'd0, 64'd0);
        step();
        applyStimulus(1'b1, LOP_PASSA, 64'h5, 64'd0);
        step();
        applyStimulus(1'b1, LOP_PASSA, 64'h6, 64'd0);
        step();
        applyStimulus(1'b0, 3'd0, 64'd0, 64'd0);
        out_ready = 1'b0;
        #1;
        checkOutput("full_out_valid", {63'd0, out_valid1}, 64'd1);
        checkOutput("full_out_result", out_result1, 64'h5);
        checkOutput("full_in_ready", {63'd0, in_ready1}, 64'd0);
        checkOutput("pre_rst_sticky_zero", {63'd0, sticky_zero1}, {63'd0, STICKY});
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", {63'd0, out_valid1}, 64'd0);
        checkOutput("mid_rst_out_result", out_result1, 64'd0);
        checkOutput("mid_rst_flags", {61'd0, out_zero1, out_negative1, out_valid4}, 64'd0);
        checkOutput("mid_rst_lz4", {60'd0, out_lane_zero4}, 64'd0);
        checkOutput("mid_rst_sticky", {60'd0, sticky_zero1, sticky_negative1, sticky_zero4, sticky_negative4}, 64'd0);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        checkOutput("rel_in_ready", {63'd0, in_ready1}, 64'd1);
        checkOutput("rel_no_replay1", {63'd0, out_valid1}, 64'd0);
        step();
        checkOutput("rel_no_replay2", {62'd0, out_valid1, out_valid4}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
